// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing for the convolution layer's weight path.
//   - fetch_state_e : weight_fetch sequencer states (IDLE / FETCH / DRAIN)
//   - WEIGHT_W      : weight word width
//   - WEIGHT_DEPTH  : number of populated weight RAM words
//   - WEIGHT_ADDR_W : weight RAM address width
package conv_pkg;

    localparam int WEIGHT_W      = 16;
    localparam int WEIGHT_DEPTH  = 5;
    localparam int WEIGHT_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage : conv_pkg

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO of {last, data}. It absorbs the weight RAM's
// one-cycle read latency so the read sequencer can keep streaming under
// downstream back-pressure. Entry 0 is always the head, so the head outputs
// come straight from flops and stay stable while nothing is popped.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   push, push_data,
//   push_last            : write {last, data} at the tail
//   pop                  : remove the head (only meaningful when head_valid)
//   occ                  : current occupancy 0..2
//   head_valid           : occupancy is non-zero
//   head_data, head_last : head entry contents
module skid_fifo2 import conv_pkg::*; #(
    parameter int DATA_W = WEIGHT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    localparam int ENTRY_W = DATA_W + 1;

    logic [ENTRY_W-1:0] e0_q, e0_d;
    logic [ENTRY_W-1:0] e1_q, e1_d;
    logic [ENTRY_W-1:0] in_s;
    logic [1:0]         occ_q, occ_d;
    logic               valid_q, valid_d;

    // Next-state for the two entries and the occupancy count.
    always_comb begin
        in_s  = {push_last, push_data};
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d  = in_s;
                    occ_d = 2'd1;
                end else if (occ_q == 2'd1) begin
                    e1_d  = in_s;
                    occ_d = 2'd2;
                end else begin
                    // Full: cannot happen while the issue rule holds; keep contents.
                    occ_d = occ_q;
                end
            end
            2'b01: begin
                if (occ_q != 2'd0) begin
                    e0_d  = e1_q;
                    occ_d = occ_q - 2'd1;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = in_s;
                end else if (occ_q == 2'd1) begin
                    e0_d = in_s;
                end else begin
                    // Pop of an empty FIFO is a no-op; the push still lands.
                    e0_d  = in_s;
                    occ_d = 2'd1;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        valid_d = (occ_d != 2'd0);
    end

    // Entry, occupancy and valid flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q    <= {ENTRY_W{1'b0}};
            e1_q    <= {ENTRY_W{1'b0}};
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign occ        = occ_q;
    assign head_valid = valid_q;
    assign head_data  = e0_q[DATA_W-1:0];
    assign head_last  = e0_q[DATA_W];

endmodule : skid_fifo2

// File: rtl/weight_fetch.sv
// weight_fetch: read-side sequencer for the convolution weight RAM.
// A start command streams min(len, DEPTH) consecutive weights beginning at
// base_addr (wrapping DEPTH-1 -> 0) out of the RAM and presents them as a
// valid/ready stream with a last-word marker.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start, base_addr, len       : command, sampled only while idle
//   busy, done                  : command in progress / one-cycle completion pulse
//   ram_read_enable,
//   ram_addr_read, ram_data_out : RAM read port (data valid the cycle after enable)
//   w_valid, w_data, w_last,
//   w_ready                     : weight stream to the MAC datapath
module weight_fetch import conv_pkg::*; #(
    parameter int DATA_W = WEIGHT_W,
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DEPTH  = WEIGHT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_read_enable,
    output logic [ADDR_W-1:0] ram_addr_read,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    input  logic              w_ready
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   emit_cnt_q, emit_cnt_d;
    logic              inflight_q, inflight_d;
    logic              last_tag_q, last_tag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        fifo_occ_s;
    logic              fifo_valid_s;
    logic              pop_s;
    logic              room_s;
    logic              issue_s;
    logic              final_xfer_s;
    logic [2:0]        pending_s;
    logic [ADDR_W:0]   base_ext_s;
    logic [ADDR_W-1:0] base_mod_s;
    logic [ADDR_W:0]   len_clamp_s;

    // Capture buffer: the RAM result is pushed the cycle after its read issue.
    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (ram_data_out),
        .push_last  (last_tag_q),
        .pop        (pop_s),
        .occ        (fifo_occ_s),
        .head_valid (fifo_valid_s),
        .head_data  (w_data),
        .head_last  (w_last)
    );

    // Issue rule, command latch values and sequencer next state.
    always_comb begin
        pop_s        = fifo_valid_s && w_ready;
        // Words already buffered plus the one still in the RAM pipe must leave
        // a free slot after this cycle's pop, so the buffer can never overflow.
        pending_s    = {1'b0, fifo_occ_s} + {2'b00, inflight_q};
        room_s       = (pending_s < (3'd2 + {2'b00, pop_s}));
        issue_s      = (state_q == ST_FETCH) && (issue_cnt_q < len_q) && room_s;
        final_xfer_s = (state_q != ST_IDLE) && pop_s && ((emit_cnt_q + CNT_ONE) == len_q);

        base_ext_s   = {1'b0, base_addr};
        base_mod_s   = ADDR_W'(base_ext_s % DEPTH_L);
        len_clamp_s  = (len > DEPTH_L) ? DEPTH_L : len;

        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        issue_cnt_d  = issue_cnt_q;
        emit_cnt_d   = emit_cnt_q;
        done_d       = 1'b0;
        inflight_d   = issue_s;
        last_tag_d   = issue_s && ((issue_cnt_q + CNT_ONE) == len_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_mod_s;
                    len_d       = len_clamp_s;
                    issue_cnt_d = {(ADDR_W+1){1'b0}};
                    emit_cnt_d  = {(ADDR_W+1){1'b0}};
                    if (len_clamp_s == {(ADDR_W+1){1'b0}}) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (issue_s) begin
                    addr_d      = (addr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : addr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                if (pop_s) begin
                    emit_cnt_d = emit_cnt_q + CNT_ONE;
                end else begin
                    emit_cnt_d = emit_cnt_q;
                end
                if (issue_cnt_d == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    emit_cnt_d = emit_cnt_q + CNT_ONE;
                end else begin
                    emit_cnt_d = emit_cnt_q;
                end
                if (final_xfer_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state, counters, RAM-pipe tracking and status flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            len_q       <= {(ADDR_W+1){1'b0}};
            issue_cnt_q <= {(ADDR_W+1){1'b0}};
            emit_cnt_q  <= {(ADDR_W+1){1'b0}};
            inflight_q  <= 1'b0;
            last_tag_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            inflight_q  <= inflight_d;
            last_tag_q  <= last_tag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Read enable depends on this cycle's pop so issue resumes as soon as space frees.
    assign ram_read_enable = issue_s;
    assign ram_addr_read   = addr_q;
    assign w_valid         = fifo_valid_s;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule : weight_fetch
